eh2_lsu_clkgate_ctl: RTL and testbench



---
 rtl/eh2_pkg.sv | 18 +
 rtl/eh2_lsu_hyst_cnt.sv | 51 +++++
 rtl/eh2_lsu_clkgate_ctl.sv | 132 +++++++++++++
 tb/tb_eh2_lsu_clkgate_ctl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eh2_pkg.sv
// Shared LSU package: per-stage clock-enable record, hysteresis limit and a
// thread-id width helper used by the LSU clock-gating controller.
package eh2_pkg;

  localparam int unsigned LSU_FREE_HYST_MAX = 255;

  // Enables for one pipeline stage: c1 header, c2 header, store-only header.
  typedef struct packed {
    logic c1;
    logic c2;
    logic store;
  } eh2_lsu_clken_t;

  function automatic int unsigned lsu_tid_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eh2_lsu_hyst_cnt.sv
// Free-clock hysteresis counter (load on activity, decrement, saturate at 0)
// plus the optional gated-cycle statistics counter (RV_LSU_CLKGATE_STATS_EN).
module eh2_lsu_hyst_cnt import eh2_pkg::*; #(
  parameter int unsigned FREE_HYST = 4,
  parameter int unsigned HYST_W    = $clog2(FREE_HYST + 1)
) (
  input  logic        free_clk,
  input  logic        rst_l,
  input  logic        activity,
`ifdef RV_LSU_CLKGATE_STATS_EN
  input  logic        stats_clr,
  output logic [31:0] gated_cycles,
`endif
  output logic        free_en
);

  // Out-of-range settings are clamped to the legal 1..LSU_FREE_HYST_MAX window.
  localparam int unsigned HYST_LOAD = (FREE_HYST > LSU_FREE_HYST_MAX) ? LSU_FREE_HYST_MAX :
                                      (FREE_HYST == 0) ? 1 : FREE_HYST;

  logic [HYST_W-1:0] r_cnt;

  always_ff @(posedge free_clk or negedge rst_l) begin
    if (!rst_l) begin
      r_cnt <= '0;
    end else if (activity) begin
      r_cnt <= HYST_W'(HYST_LOAD);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - HYST_W'(1);
    end
  end

  assign free_en = activity | (r_cnt != '0);

`ifdef RV_LSU_CLKGATE_STATS_EN
  logic [31:0] r_gated;

  always_ff @(posedge free_clk or negedge rst_l) begin
    if (!rst_l) begin
      r_gated <= '0;
    end else if (stats_clr) begin
      r_gated <= '0;
    end else if (!free_en && (r_gated != '1)) begin
      r_gated <= r_gated + 32'd1;
    end
  end

  assign gated_cycles = r_gated;
`endif

endmodule

// File: rtl/eh2_lsu_clkgate_ctl.sv
// Parametrised LSU clock-gating controller: stage c1/c2/store clocks, per-thread
// bus-buffer clocks, bus-master and free clocks. Optional: RV_LSU_CLKGATE_STATS_EN.
module eh2_lsu_clkgate_ctl import eh2_pkg::*; #(
  parameter  int unsigned NUM_STAGES  = 5,
  parameter  int unsigned NUM_THREADS = 2,
  parameter  int unsigned FREE_HYST   = 4,
  parameter  int unsigned HYST_W      = $clog2(FREE_HYST + 1),
  localparam int unsigned TID_W       = lsu_tid_w(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   free_clk,
  input  logic                   rst_l,
  input  logic                   scan_mode,
  input  logic                   clk_override,
  input  logic [NUM_STAGES:0]    stage_vld,
  input  logic [NUM_STAGES:0]    stage_store,
  input  logic                   dma_dccm_req,
  input  logic                   dma_mem_write,
  input  logic                   busreq_last,
  input  logic [TID_W-1:0]       busreq_tid,
  input  logic [NUM_THREADS-1:0] bus_pend,
  input  logic [NUM_THREADS-1:0] bus_empty,
  input  logic [NUM_THREADS-1:0] stbuf_empty,
  input  logic [NUM_THREADS-1:0] lr_vld,
  input  logic                   lsu_bus_clk_en,
`ifdef RV_LSU_CLKGATE_STATS_EN
  input  logic                   stats_clr,
  output logic [31:0]            gated_cycles,
`endif
  output logic [NUM_STAGES:1]    c1_clk,
  output logic [NUM_STAGES:1]    c2_clk,
  output logic [NUM_STAGES:1]    store_c1_clk,
  output logic [NUM_THREADS-1:0] bus_ibuf_clk,
  output logic [NUM_THREADS-1:0] bus_obuf_clk,
  output logic [NUM_THREADS-1:0] bus_buf_clk,
  output logic                   busm_clk,
  output logic                   free_c2_clk,
  output logic [NUM_STAGES:1]    c1_en,
  output logic [NUM_STAGES:1]    c2_en,
  output logic                   free_en
);

  localparam int unsigned NG = 3 * NUM_STAGES + 3 * NUM_THREADS + 2;

  logic                   w_ovr;
  logic                   w_activity;
  logic [NUM_STAGES:0]    r_c1_en_q;
  eh2_lsu_clken_t         w_en [1:NUM_STAGES];
  logic [NUM_STAGES:1]    w_store_en;
  logic [NUM_THREADS-1:0] w_hit;
  logic [NUM_THREADS-1:0] w_ibuf_en;
  logic [NUM_THREADS-1:0] w_obuf_en;
  logic [NUM_THREADS-1:0] w_buf_en;
  logic [NG-1:0]          w_gate_en;
  logic [NG-1:0]          w_gclk;
  logic                   w_unused_store;

  assign w_ovr          = clk_override;
  assign w_unused_store = stage_store[NUM_STAGES];

  // Slot 0 of the shift chain is the decode valid; slot s tracks c1_en[s].
  always_ff @(posedge free_clk or negedge rst_l) begin
    if (!rst_l) begin
      r_c1_en_q <= '0;
    end else begin
      r_c1_en_q[0] <= stage_vld[0];
      for (int unsigned s = 1; s <= NUM_STAGES; s++) begin
        r_c1_en_q[s] <= w_en[s].c1;
      end
    end
  end

  for (genvar s = 1; s <= NUM_STAGES; s++) begin : g_stage
    logic w_c1;
    logic w_st_sel;
    assign w_c1     = stage_vld[s-1] | r_c1_en_q[s-1] | w_ovr |
                      ((s == 1) ? dma_dccm_req : 1'b0);
    assign w_st_sel = stage_store[s-1] | ((s == 1) ? dma_mem_write : 1'b0);
    assign w_en[s]  = '{c1: w_c1, c2: w_c1 | r_c1_en_q[s], store: (w_c1 & w_st_sel) | w_ovr};
  end

  always_comb begin
    c1_en      = '0;
    c2_en      = '0;
    w_store_en = '0;
    for (int unsigned s = 1; s <= NUM_STAGES; s++) begin
      c1_en[s]      = w_en[s].c1;
      c2_en[s]      = w_en[s].c2;
      w_store_en[s] = w_en[s].store;
    end
  end

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
    assign w_hit[t]     = busreq_last & (busreq_tid == TID_W'(t));
    assign w_ibuf_en[t] = w_hit[t] | w_ovr;
    assign w_obuf_en[t] = (bus_pend[t] | w_hit[t] | w_ovr) & lsu_bus_clk_en;
    assign w_buf_en[t]  = ~bus_empty[t] | w_hit[t] | w_ovr;
  end

  assign w_activity = (|stage_vld) | (|lr_vld) | ~(&bus_empty) | ~(&stbuf_empty) | w_ovr;

  eh2_lsu_hyst_cnt #(
    .FREE_HYST (FREE_HYST),
    .HYST_W    (HYST_W)
  ) u_hyst (
    .free_clk     (free_clk),
    .rst_l        (rst_l),
    .activity     (w_activity),
`ifdef RV_LSU_CLKGATE_STATS_EN
    .stats_clr    (stats_clr),
    .gated_cycles (gated_cycles),
`endif
    .free_en      (free_en)
  );

  // Top two slots (busm, obuf) are the bus-ratio rvclkhdr domain; the rest are
  // rvoclkhdr. Both share the latch-while-low / AND structure with scan bypass.
  assign w_gate_en = {lsu_bus_clk_en, w_obuf_en, free_en, w_buf_en, w_ibuf_en,
                      w_store_en, c2_en, c1_en};

  for (genvar g = 0; g < NG; g++) begin : g_hdr
    logic r_en_lat;
    always_latch begin
      if (!clk) r_en_lat <= w_gate_en[g] | scan_mode;
    end
    assign w_gclk[g] = clk & r_en_lat;
  end

  assign {busm_clk, bus_obuf_clk, free_c2_clk, bus_buf_clk, bus_ibuf_clk,
          store_c1_clk, c2_clk, c1_clk} = w_gclk;

endmodule

// File: tb/tb_eh2_lsu_clkgate_ctl.sv
// Self-checking bench for eh2_lsu_clkgate_ctl: directed walk/hysteresis/thread/
// override/reset steps, then randomized traffic against a history-based model.
module tb_eh2_lsu_clkgate_ctl;

  localparam int NS   = 5;
  localparam int NT   = 2;
  localparam int FH   = 4;
  localparam int TW   = 1;
  localparam int HMAX = 2048;

  logic          clk = 1'b0;
  logic          free_clk;
  logic          rst_l, scan_mode, clk_override;
  logic [NS:0]   stage_vld, stage_store;
  logic          dma_dccm_req, dma_mem_write, busreq_last, lsu_bus_clk_en;
  logic [TW-1:0] busreq_tid;
  logic [NT-1:0] bus_pend, bus_empty, stbuf_empty, lr_vld;
  logic [NS:1]   c1_clk, c2_clk, store_c1_clk, c1_en, c2_en;
  logic [NT-1:0] bus_ibuf_clk, bus_obuf_clk, bus_buf_clk;
  logic          busm_clk, free_c2_clk, free_en;
`ifdef RV_LSU_CLKGATE_STATS_EN
  logic          stats_clr;
  logic [31:0]   gated_cycles;
  logic [31:0]   exp_gc;
`endif

  always #5 clk = ~clk;
  assign free_clk = clk;

  eh2_lsu_clkgate_ctl #(.NUM_STAGES(NS), .NUM_THREADS(NT), .FREE_HYST(FH)) dut (
    .clk(clk), .free_clk(free_clk), .rst_l(rst_l), .scan_mode(scan_mode),
    .clk_override(clk_override), .stage_vld(stage_vld), .stage_store(stage_store),
    .dma_dccm_req(dma_dccm_req), .dma_mem_write(dma_mem_write),
    .busreq_last(busreq_last), .busreq_tid(busreq_tid), .bus_pend(bus_pend),
    .bus_empty(bus_empty), .stbuf_empty(stbuf_empty), .lr_vld(lr_vld),
    .lsu_bus_clk_en(lsu_bus_clk_en),
`ifdef RV_LSU_CLKGATE_STATS_EN
    .stats_clr(stats_clr), .gated_cycles(gated_cycles),
`endif
    .c1_clk(c1_clk), .c2_clk(c2_clk), .store_c1_clk(store_c1_clk),
    .bus_ibuf_clk(bus_ibuf_clk), .bus_obuf_clk(bus_obuf_clk), .bus_buf_clk(bus_buf_clk),
    .busm_clk(busm_clk), .free_c2_clk(free_c2_clk), .c1_en(c1_en), .c2_en(c2_en),
    .free_en(free_en)
  );

  // Input history per cycle; entries older than cb were wiped by a reset.
  logic [NS:0] hv   [HMAX];
  logic        hovr [HMAX];
  logic        hdma [HMAX];
  logic        hact [HMAX];
  int          cyc, cb, checks, failures;

  logic [NS:1] pc1, pc2, pst;
  logic [NT-1:0] pib, pob, pbf;
  logic        pfree, pbusm, pscan;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // A stage-0 valid at cycle k reaches stage s at k+s-1 and k+s; a source
  // feeding stage j at cycle k reaches stage s at k+(s-j).
  function automatic logic c1_model(input int s, input int m);
    logic r = 1'b0;
    for (int j = 1; j <= s; j++) begin
      int k = m - (s - j);
      if (k >= cb) r = r | hv[k][j-1] | hovr[k] | ((j == 1) && hdma[k]);
    end
    if (m - s >= cb) r = r | hv[m-s][0];
    return r;
  endfunction

  function automatic logic free_model(input int m);
    for (int k = m; k >= m - FH; k--) begin
      if (k >= cb && hact[k]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic neg_chk();
    logic [NS:1] e1, e2, est;
    logic [NT-1:0] eib, eob, ebf;
    logic hit, efree;
    @(negedge clk);
    if (!rst_l) cb = cyc;
    hv[cyc]   = stage_vld;
    hovr[cyc] = clk_override;
    hdma[cyc] = dma_dccm_req;
    hact[cyc] = (|stage_vld) | (|lr_vld) | !(&bus_empty) | !(&stbuf_empty) | clk_override;
    for (int s = 1; s <= NS; s++) begin
      e1[s]  = c1_model(s, cyc);
      e2[s]  = e1[s] | c1_model(s, cyc - 1);
      est[s] = (e1[s] & (stage_store[s-1] | ((s == 1) && dma_mem_write))) | clk_override;
    end
    for (int t = 0; t < NT; t++) begin
      hit    = busreq_last && (busreq_tid == TW'(t));
      eib[t] = hit | clk_override;
      eob[t] = (bus_pend[t] | hit | clk_override) & lsu_bus_clk_en;
      ebf[t] = !bus_empty[t] | hit | clk_override;
    end
    efree = free_model(cyc);
    chk("c1_en", c1_en, e1);
    chk("c2_en", c2_en, e2);
    chk("free_en", free_en, efree);
    chk("gclk_low", {c1_clk, c2_clk, store_c1_clk, bus_ibuf_clk, bus_obuf_clk,
                     bus_buf_clk, busm_clk, free_c2_clk}, 0);
`ifdef RV_LSU_CLKGATE_STATS_EN
    if (!rst_l) exp_gc = 0;
    chk("gated_cycles", gated_cycles, exp_gc);
`endif
    pc1 = e1; pc2 = e2; pst = est; pib = eib; pob = eob; pbf = ebf;
    pfree = efree; pbusm = lsu_bus_clk_en; pscan = scan_mode;
  endtask

  task automatic pos_chk();
    @(posedge clk);
    if (!rst_l) cb = cyc + 1;
`ifdef RV_LSU_CLKGATE_STATS_EN
    if (!rst_l || stats_clr) exp_gc = 0;
    else if (!pfree && exp_gc != 32'hFFFF_FFFF) exp_gc++;
`endif
    cyc++;
    #1;
    chk("c1_clk", c1_clk, pc1 | {NS{pscan}});
    chk("c2_clk", c2_clk, pc2 | {NS{pscan}});
    chk("store_c1_clk", store_c1_clk, pst | {NS{pscan}});
    chk("bus_ibuf_clk", bus_ibuf_clk, pib | {NT{pscan}});
    chk("bus_obuf_clk", bus_obuf_clk, pob | {NT{pscan}});
    chk("bus_buf_clk", bus_buf_clk, pbf | {NT{pscan}});
    chk("busm_clk", busm_clk, pbusm | pscan);
    chk("free_c2_clk", free_c2_clk, pfree | pscan);
  endtask

  task automatic tick();
    neg_chk();
    pos_chk();
  endtask

  task automatic idle();
    scan_mode = 0; clk_override = 0; stage_vld = '0; stage_store = '0;
    dma_dccm_req = 0; dma_mem_write = 0; busreq_last = 0; busreq_tid = '0;
    bus_pend = '0; bus_empty = '1; stbuf_empty = '1; lr_vld = '0; lsu_bus_clk_en = 1;
`ifdef RV_LSU_CLKGATE_STATS_EN
    stats_clr = 0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NS:1] walk [8];
    walk = '{5'b00000, 5'b00001, 5'b00011, 5'b00110, 5'b01100, 5'b11000, 5'b10000, 5'b00000};
    checks = 0; failures = 0; cyc = 0; cb = 0;
`ifdef RV_LSU_CLKGATE_STATS_EN
    exp_gc = 0;
`endif
    for (int i = 0; i < HMAX; i++) begin
      hv[i] = '0; hovr[i] = 0; hdma[i] = 0; hact[i] = 0;
    end
    idle();
    rst_l = 0;
    neg_chk();
    chk("rst_c1_en", c1_en, 0);
    chk("rst_c2_en", c2_en, 0);
    chk("rst_free_en", free_en, 0);
    pos_chk();
    rst_l = 1;
    while (cyc < 10) tick();

    // Single decode valid walks down the stages.
    stage_vld = 6'b000001;
    for (int i = 0; i < 7; i++) begin
      neg_chk();
      chk("walk_c1_en", c1_en, walk[i+1]);
      chk("walk_c2_en", c2_en, walk[i+1] | walk[i]);
      chk("walk_free_en", free_en, (i <= 4) ? 1 : 0);
      pos_chk();
      idle();
    end
    while (cyc < 20) tick();

    // Reload in the cycle the counter reaches 1 leaves no gap.
    lr_vld = 2'b01;
    for (int i = 0; i < 10; i++) begin
      neg_chk();
      chk("reload_free_en", free_en, (i <= 8) ? 1 : 0);
      pos_chk();
      idle();
      if (i == 3) lr_vld = 2'b01;
    end
    tick(); tick();

    // Bus request for thread 1 with the bus-ratio enable low.
    busreq_last = 1; busreq_tid = 1'b1; lsu_bus_clk_en = 0;
    neg_chk();
    pos_chk();
    chk("thr_ibuf_clk", bus_ibuf_clk, 2'b10);
    chk("thr_obuf_clk", bus_obuf_clk, 2'b00);
    chk("thr_buf_clk", bus_buf_clk, 2'b10);
    idle();
    tick();

    clk_override = 1;
    for (int i = 0; i < 3; i++) begin
      neg_chk();
      chk("ovr_c1_en", c1_en, 5'h1F);
      chk("ovr_c2_en", c2_en, 5'h1F);
      chk("ovr_free_en", free_en, 1);
      pos_chk();
      chk("ovr_thread_clks", {bus_ibuf_clk, bus_obuf_clk, bus_buf_clk}, 6'h3F);
      chk("ovr_store_clk", store_c1_clk, 5'h1F);
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      neg_chk();
      chk("ovr_rel_free_en", free_en, (i < 4) ? 1 : 0);
      pos_chk();
    end

    // Reset while the counter and the shift chain are non-zero.
    stage_vld = 6'b000100; tick(); idle();
    tick();
    stage_vld = 6'b000001; tick(); idle();
    rst_l = 0;
    neg_chk();
    chk("midrst_free_en", free_en, 0);
    chk("midrst_c1_en", c1_en, 0);
    chk("midrst_c2_en", c2_en, 0);
    pos_chk();
    lr_vld = 2'b01;
    neg_chk();
    chk("rst_free_follows_act", free_en, 1);
    pos_chk();
    idle();
    rst_l = 1;
    tick();

    for (int n = 0; n < 400; n++) begin
      stage_vld      = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      stage_vld      = {stage_vld[NS-1:0], ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0};
      stage_store    = ($urandom) & 6'h3F;
      dma_dccm_req   = ($urandom_range(0, 7) == 0);
      dma_mem_write  = $urandom_range(0, 1);
      busreq_last    = ($urandom_range(0, 5) == 0);
      busreq_tid     = $urandom_range(0, 1);
      bus_pend       = ($urandom_range(0, 3) == 0) ? NT'($urandom) : '0;
      bus_empty      = ($urandom_range(0, 5) == 0) ? NT'($urandom) : '1;
      stbuf_empty    = ($urandom_range(0, 7) == 0) ? NT'($urandom) : '1;
      lr_vld         = ($urandom_range(0, 9) == 0) ? NT'($urandom) : '0;
      lsu_bus_clk_en = $urandom_range(0, 1);
      clk_override   = ($urandom_range(0, 24) == 0);
      scan_mode      = ($urandom_range(0, 9) == 0);
      rst_l          = ($urandom_range(0, 79) != 0);
`ifdef RV_LSU_CLKGATE_STATS_EN
      stats_clr      = ($urandom_range(0, 49) == 0);
`endif
      if ($urandom_range(0, 1) == 0) begin
        stage_vld = '0; lr_vld = '0; bus_empty = '1; stbuf_empty = '1; clk_override = 0;
      end
      tick();
    end
    idle();
    rst_l = 1;
    for (int i = 0; i < 8; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
